mem_access: RTL

Memory-access stage of the MartianMIPS pipeline, directly downstream of the execute stage. It accepts the execute result (register write enable, destination address, ALU result used as data or effective address), performs any load/store over a single-outstanding req/ack data bus, and hands a registered writeback record to the WB stage. Non-memory instructions pass through with one cycle of latency. Memory instructions stall the upstream stage until the bus access completes, faults on misalignment, or times out.

---
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage and the memory system.
// Single outstanding request; bus_ack_i is a one-cycle completion strobe.
interface mem_access_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_access.sv
// MartianMIPS memory-access stage: passes non-memory records through in one cycle,
// runs loads/stores over a req/ack bus with alignment checking and a wait timeout.
//
// state  | meaning
// IDLE   | ready for a record; NONE and misaligned records complete in one cycle
// BUS    | bus request outstanding, waiting for ack or timeout; upstream stalled
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    output logic        ready_o,
    input  logic [3:0]  memop_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    mem_access_if.master bus,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        align_err_o,
    output logic        bus_err_o
);

    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt;
    logic [3:0]  r_op;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_addr;
    logic        r_bus_req, r_bus_we;
    logic [31:0] r_bus_addr, r_bus_wdata;
    logic [3:0]  r_bus_sel;
    logic        r_wb_valid, r_wb_we, r_align_err, r_bus_err;
    logic [4:0]  r_wb_waddr;
    logic [31:0] r_wb_wdata;

    logic        w_accept, w_is_load, w_is_store, w_is_mem, w_is_byte, w_is_half, w_is_word;
    logic        w_misaligned, w_pass, w_start, w_ack_done, w_timeout;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata, w_load_data;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;

    assign ready_o  = !rst && (r_state == S_IDLE);
    assign w_accept = ex_valid_i && ready_o;

    assign w_is_load  = memop_i inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    assign w_is_store = memop_i inside {OP_SB, OP_SH, OP_SW};
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_is_byte  = memop_i inside {OP_LB, OP_LBU, OP_SB};
    assign w_is_half  = memop_i inside {OP_LH, OP_LHU, OP_SH};
    assign w_is_word  = memop_i inside {OP_LW, OP_SW};
    assign w_misaligned = (w_is_half && result_i[0]) || (w_is_word && (result_i[1:0] != 2'b00));

    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = 32'd0;
        if (w_is_byte) begin
            w_sel = 4'b0001 << result_i[1:0];
        end else if (w_is_half) begin
            w_sel = result_i[1] ? 4'b1100 : 4'b0011;
        end
        if (w_is_store) begin
            if (w_is_byte)      w_wdata = {4{store_data_i[7:0]}};
            else if (w_is_half) w_wdata = {2{store_data_i[15:0]}};
            else                w_wdata = store_data_i;
        end
    end

    // Lane extraction uses the latched address; rdata is only meaningful during ack.
    always_comb begin
        w_rbyte     = bus.bus_rdata_i[8*r_addr[1:0] +: 8];
        w_rhalf     = r_addr[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
        w_load_data = 32'd0;
        case (r_op)
            OP_LB:   w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
            OP_LBU:  w_load_data = {24'd0, w_rbyte};
            OP_LH:   w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
            OP_LHU:  w_load_data = {16'd0, w_rhalf};
            OP_LW:   w_load_data = bus.bus_rdata_i;
            default: w_load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pass      = 1'b0;
        w_start     = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mem && !w_misaligned) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_BUS;
                    end else begin
                        w_pass = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (bus.bus_ack_i) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;  r_op <= 4'd0;  r_we <= 1'b0;  r_waddr <= 5'd0;  r_addr <= 32'd0;
            r_bus_req <= 1'b0;  r_bus_we <= 1'b0;  r_bus_addr <= 32'd0;
            r_bus_sel <= 4'd0;  r_bus_wdata <= 32'd0;
            r_wb_valid <= 1'b0;  r_wb_we <= 1'b0;  r_wb_waddr <= 5'd0;  r_wb_wdata <= 32'd0;
            r_align_err <= 1'b0;  r_bus_err <= 1'b0;
        end else begin
            r_wb_valid  <= w_pass || w_ack_done || w_timeout;
            r_wb_we     <= 1'b0;
            r_wb_waddr  <= 5'd0;
            r_wb_wdata  <= 32'd0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_pass) begin
                // A memop reaching the pass path can only be a misaligned one.
                r_wb_we     <= we_i && !w_is_mem;
                r_wb_waddr  <= waddr_i;
                r_wb_wdata  <= result_i;
                r_align_err <= w_is_mem;
            end
            if (w_start) begin
                r_op        <= memop_i;
                r_we        <= we_i;
                r_waddr     <= waddr_i;
                r_addr      <= result_i;
                r_cnt       <= 8'd0;
                r_bus_req   <= 1'b1;
                r_bus_we    <= w_is_store;
                r_bus_addr  <= {result_i[31:2], 2'b00};
                r_bus_sel   <= w_sel;
                r_bus_wdata <= w_wdata;
            end
            if (w_ack_done || w_timeout) begin
                r_bus_req   <= 1'b0;
                r_bus_we    <= 1'b0;
                r_bus_addr  <= 32'd0;
                r_bus_sel   <= 4'd0;
                r_bus_wdata <= 32'd0;
                r_wb_waddr  <= r_waddr;
            end
            if (w_ack_done) begin
                r_wb_we    <= r_we && (r_op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW});
                r_wb_wdata <= w_load_data;
            end
            if (w_timeout) begin
                r_bus_err  <= 1'b1;
                r_wb_wdata <= r_addr;
            end
            if ((r_state == S_BUS) && !w_ack_done && !w_timeout) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign bus.bus_req_o   = r_bus_req;
    assign bus.bus_we_o    = r_bus_we;
    assign bus.bus_addr_o  = r_bus_addr;
    assign bus.bus_sel_o   = r_bus_sel;
    assign bus.bus_wdata_o = r_bus_wdata;

    assign wb_valid_o  = r_wb_valid;
    assign wb_we_o     = r_wb_we;
    assign wb_waddr_o  = r_wb_waddr;
    assign wb_wdata_o  = r_wb_wdata;
    assign align_err_o = r_align_err;
    assign bus_err_o   = r_bus_err;

endmodule
